// File: rtl/led_matrix_out.sv
// Double-buffered 8x8 LED matrix output peripheral: CPU fills the back buffer over I/O
// ports, swaps at a frame boundary, and rows are scanned one per SCAN_DIV clocks.
// Optional: define LED_ACTIVE_LOW_EN to drive led_x/led_y inverted for an active-low matrix.
module led_matrix_out #(
  parameter logic [7:0]  BASE_ADDR = 8'h10,
  parameter int unsigned SCAN_DIV  = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       io_en,
  input  logic       io_we,
  input  logic [7:0] io_addr,
  input  logic [7:0] io_wdata,
  output logic [7:0] io_rdata,
  output logic [7:0] led_x,
  output logic [7:0] led_y
);

  localparam logic [15:0] LAST_CNT = 16'(SCAN_DIV - 1);

  logic [7:0]  fb_q [2][8];
  logic [7:0]  fb_d [2][8];
  logic        buf_sel_q, buf_sel_d;
  logic [2:0]  row_ptr_q, row_ptr_d;
  logic [15:0] presc_q, presc_d;
  logic        swap_pending_q, swap_pending_d;
  logic        frame_tog_q, frame_tog_d;
  logic [7:0]  led_x_q, led_x_d;
  logic [7:0]  led_y_q, led_y_d;
  logic [7:0]  rdata_q, rdata_d;

  logic [7:0] off;
  logic       hit, wr_hit, rd_hit, ctrl_wr;
  logic       tick, do_swap, back_sel, disp_sel;

  assign off      = io_addr - BASE_ADDR;
  assign hit      = io_en && (off < 8'd10);
  assign wr_hit   = hit && io_we;
  assign rd_hit   = hit && !io_we;
  assign ctrl_wr  = wr_hit && (off == 8'd8);
  assign tick     = (presc_q == LAST_CNT);
  assign do_swap  = tick && (row_ptr_q == 3'd0) && swap_pending_q;
  assign back_sel = ~buf_sel_q;
  // On a swap edge the row-0 load already comes from the buffer that is becoming front.
  assign disp_sel = do_swap ? back_sel : buf_sel_q;

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    fb_d           = fb_q;
    buf_sel_d      = buf_sel_q;
    row_ptr_d      = row_ptr_q;
    presc_d        = tick ? 16'd0 : presc_q + 16'd1;
    swap_pending_d = swap_pending_q;
    frame_tog_d    = frame_tog_q;
    led_x_d        = led_x_q;
    led_y_d        = led_y_q;
    rdata_d        = rdata_q;

    if (wr_hit && (off < 8'd8)) fb_d[back_sel][off[2:0]] = io_wdata;
    if (ctrl_wr && io_wdata[1]) begin
      for (int r = 0; r < 8; r++) fb_d[back_sel][r] = 8'h00;
    end

    if (tick) begin
      led_y_d   = 8'b1 << row_ptr_q;
      led_x_d   = fb_q[disp_sel][row_ptr_q];
      row_ptr_d = row_ptr_q + 3'd1;
    end

    if (do_swap) begin
      buf_sel_d      = ~buf_sel_q;
      swap_pending_d = 1'b0;
      frame_tog_d    = ~frame_tog_q;
    end
    // A request landing on the swap edge re-arms for the next boundary.
    if (ctrl_wr && io_wdata[0]) swap_pending_d = 1'b1;

    if (rd_hit) begin
      case (off)
        8'd8:    rdata_d = 8'h00;
        8'd9:    rdata_d = {6'b0, frame_tog_q, swap_pending_q};
        default: rdata_d = fb_q[back_sel][off[2:0]];
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers
  // update together from the values computed above.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the frame buffers are flops, not RAM, and must read back as zero after
      // reset, so they are reset explicitly along with the control state.
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 8; r++) fb_q[b][r] <= 8'h00;
      end
      buf_sel_q      <= 1'b0;
      row_ptr_q      <= 3'd0;
      presc_q        <= 16'd0;
      swap_pending_q <= 1'b0;
      frame_tog_q    <= 1'b0;
      led_x_q        <= 8'h00;
      led_y_q        <= 8'h00;
      rdata_q        <= 8'h00;
    end else begin
      fb_q           <= fb_d;
      buf_sel_q      <= buf_sel_d;
      row_ptr_q      <= row_ptr_d;
      presc_q        <= presc_d;
      swap_pending_q <= swap_pending_d;
      frame_tog_q    <= frame_tog_d;
      led_x_q        <= led_x_d;
      led_y_q        <= led_y_d;
      rdata_q        <= rdata_d;
    end
  end

  assign io_rdata = rdata_q;

`ifdef LED_ACTIVE_LOW_EN
  assign led_x = ~led_x_q;
  assign led_y = ~led_y_q;
`else
  assign led_x = led_x_q;
  assign led_y = led_y_q;
`endif

endmodule

// File: tb/tb_led_matrix_out.sv
// Directed self-checking bench for led_matrix_out with SCAN_DIV = 4 (frame = 32 cycles).
// Honours LED_ACTIVE_LOW_EN by inverting expected LED values.
module tb_led_matrix_out;

  localparam logic [7:0] BASE = 8'h10;
`ifdef LED_ACTIVE_LOW_EN
  localparam logic [7:0] INV = 8'hFF;
`else
  localparam logic [7:0] INV = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       reset, io_en, io_we;
  logic [7:0] io_addr, io_wdata, io_rdata, led_x, led_y;

  int checks = 0;
  int errors = 0;
  int n = 0;  // clock edges since reset release

  led_matrix_out #(.BASE_ADDR(BASE), .SCAN_DIV(4)) dut (
    .clk(clk), .reset(reset), .io_en(io_en), .io_we(io_we), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .led_x(led_x), .led_y(led_y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (n=%0d)", tag, got, exp, n);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    io_en = 1'b1; io_we = 1'b1; io_addr = a; io_wdata = d;
    step();
    io_en = 1'b0; io_we = 1'b0;
  endtask

  task automatic io_read(input logic [7:0] a);
    io_en = 1'b1; io_we = 1'b0; io_addr = a;
    step();
    io_en = 1'b0;
  endtask

  // Advance until the edge count lands on phase m of the 32-cycle frame.
  task automatic run_to(input int m);
    for (int i = 0; i < 64; i++) begin
      if (n % 32 == m) return;
      step();
    end
    check("run_to_bound", 8'h01, 8'h00);
  endtask

  task automatic check_leds(input string tag, input logic [7:0] x, input logic [7:0] y);
    check({tag, "_x"}, led_x, x ^ INV);
    check({tag, "_y"}, led_y, y ^ INV);
  endtask

  initial begin
    logic [7:0] ey;
    reset = 1'b1; io_en = 1'b0; io_we = 1'b0; io_addr = 8'h00; io_wdata = 8'h00;
    step(); step();
    check_leds("rst", 8'h00, 8'h00);
    check("rst_rdata", io_rdata, 8'h00);
    reset = 1'b0;
    n = 0;

    // Idle scan: blank columns, one-hot row walk, first change 4 cycles after release.
    for (int k = 1; k <= 36; k++) begin
      step();
      ey = (n < 4) ? 8'h00 : 8'(1 << (((n / 4) - 1) % 8));
      check_leds("scan", 8'h00, ey);
    end

    // Fill back buffer, request swap, verify pending then the new frame.
    run_to(5);
    for (int r = 0; r < 8; r++) io_write(BASE + 8'(r), 8'hA0 + 8'(r));
    io_write(BASE + 8'd8, 8'h01);
    io_read(BASE + 8'd9);
    check("status_pending", io_rdata, 8'h01);
    run_to(4);
    check_leds("swap_row0", 8'hA0, 8'h01);
    io_read(BASE + 8'd9);
    check("status_swapped", io_rdata, 8'h02);
    for (int r = 1; r < 8; r++) begin
      run_to((4 + 4 * r) % 32);
      check_leds("frame_row", 8'hA0 + 8'(r), 8'(1 << r));
    end

    // Read latency and out-of-window reads.
    io_write(BASE + 8'd3, 8'h5C);
    check("wr_no_rdata", io_rdata, 8'h02);
    io_read(BASE + 8'd3);
    check("rd_row3", io_rdata, 8'h5C);
    io_read(BASE + 8'd10);
    check("rd_above", io_rdata, 8'h5C);
    io_read(BASE - 8'd1);
    check("rd_below", io_rdata, 8'h5C);
    io_read(BASE + 8'd8);
    check("rd_ctrl", io_rdata, 8'h00);

    // Clear back + swap: blank frame, old pattern now in back.
    io_write(BASE + 8'd8, 8'h03);
    run_to(4);
    check_leds("clr_row0", 8'h00, 8'h01);
    run_to(8);
    check_leds("clr_row1", 8'h00, 8'h02);
    io_read(BASE + 8'd0);
    check("old_row0", io_rdata, 8'hA0);
    io_read(BASE + 8'd7);
    check("old_row7", io_rdata, 8'hA7);
    io_read(BASE + 8'd9);
    check("status_clr", io_rdata, 8'h00);

    // Two requests in one frame yield a single swap.
    io_write(BASE + 8'd8, 8'h01);
    io_write(BASE + 8'd8, 8'h01);
    io_read(BASE + 8'd9);
    check("status_dbl", io_rdata, 8'h01);
    run_to(4);
    check_leds("dbl_row0", 8'hA0, 8'h01);
    io_read(BASE + 8'd9);
    check("status_dbl_done", io_rdata, 8'h02);
    run_to(4);
    check_leds("dbl_next", 8'hA0, 8'h01);
    io_read(BASE + 8'd9);
    check("status_dbl_next", io_rdata, 8'h02);

    // Row write on the swap edge: row 0 shows the pre-write value this frame.
    io_write(BASE + 8'd8, 8'h01);
    run_to(3);
    io_write(BASE + 8'd0, 8'h55);
    check_leds("wr_at_swap", 8'h00, 8'h01);
    io_read(BASE + 8'd9);
    check("status_wr_swap", io_rdata, 8'h00);

    // Swap request on the swap edge re-arms for the next boundary.
    io_write(BASE + 8'd8, 8'h01);
    run_to(3);
    io_write(BASE + 8'd8, 8'h01);
    check_leds("ctrl_at_swap", 8'hA0, 8'h01);
    io_read(BASE + 8'd9);
    check("status_rearm", io_rdata, 8'h03);
    run_to(4);
    check_leds("rearm_swap", 8'h55, 8'h01);
    io_read(BASE + 8'd9);
    check("status_rearm_done", io_rdata, 8'h00);

    // Reset mid-frame with a swap pending.
    io_write(BASE + 8'd8, 8'h01);
    io_read(BASE + 8'd9);
    check("status_pre_rst", io_rdata, 8'h01);
    step(); step();
    reset = 1'b1;
    step();
    check_leds("midrst", 8'h00, 8'h00);
    check("midrst_rdata", io_rdata, 8'h00);
    reset = 1'b0;
    n = 0;
    io_read(BASE + 8'd9);
    check("status_post_rst", io_rdata, 8'h00);
    io_read(BASE + 8'd0);
    check("buf_post_rst", io_rdata, 8'h00);
    step();
    check_leds("post_rst_blank", 8'h00, 8'h00);
    step();
    check_leds("post_rst_row0", 8'h00, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_matrix_out.md
Name: led_matrix_out

Overview:
- CPU-facing output peripheral driving the 8x8 LED matrix through led_x (column data) and led_y (row select).
- It is the output-direction counterpart of the button input registers.
- The CPU writes row bitmaps into a back frame buffer through I/O port writes, then requests a swap.
- The block time-multiplexes the front buffer onto the matrix one row at a time, and performs the swap only at a frame boundary so the display never tears.

Parameters:
- BASE_ADDR, 8'h10, first I/O address of the block's 10-address window.
- SCAN_DIV, 1000, clk cycles per displayed row; legal range 2..65535.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high reset.
- io_en, input, 1, single-cycle I/O access strobe from CPU.
- io_we, input, 1, 1 = write, 0 = read; qualified by io_en.
- io_addr, input, 8, I/O address (addr_bus).
- io_wdata, input, 8, write data.
- io_rdata, output, 8, read data; registered.
- led_x, output, 8, column data for the currently selected row.
- led_y, output, 8, one-hot row select.

Behaviour:
- Reset and clock: one clock domain, clk. reset is synchronous and active-high, and reset has priority over all other activity.
- Reset values:
  - led_x = 8'h00, led_y = 8'h00 (matrix blank).
  - io_rdata = 8'h00.
  - Both frame buffers all zero.
  - buf_sel = 0, row_ptr = 0, prescaler = 0.
  - swap_pending = 0, frame_tog = 0.
- Storage: two 8x8-bit buffers, buf[0] and buf[1]. front = buf[buf_sel]; back = buf[~buf_sel].
- Address map, relative to BASE_ADDR:
  - +0..+7: write stores io_wdata into back row N; read returns back row N.
  - +8 CTRL (write only): bit0 = request swap (sets swap_pending); bit1 = clear back buffer (all 8 rows to 0 in the same cycle); other bits ignored. Reads return 0.
  - +9 STATUS (read only): bit0 = swap_pending, bit1 = frame_tog, bits 7:2 = 0. Writes are ignored.
  - Addresses outside the window: writes are ignored; no read response, so io_rdata is left unchanged.
- Read latency: io_rdata updates on the clock edge after an io_en && !io_we cycle that hits the window. It holds its value otherwise.
- Scan timing:
  - The prescaler counts 0..SCAN_DIV-1 and wraps. tick = (prescaler == SCAN_DIV-1).
  - On tick: led_y <= 1 << row_ptr, led_x <= displayed front row[row_ptr], row_ptr <= row_ptr+1 (wraps 7 -> 0).
  - The first row is visible SCAN_DIV cycles after reset is released. Each row is held exactly SCAN_DIV cycles. Full frame = 8*SCAN_DIV cycles.
- Frame boundary (tick while row_ptr == 0):
  - If swap_pending: buf_sel flips, swap_pending clears, frame_tog toggles. led_x is loaded from the new front row 0 on that same edge.
  - If swap_pending is clear: nothing changes.
- Simultaneous events:
  - Back-row write on the same cycle as a boundary swap: the write targets the buffer that is back at the start of that cycle, which becomes front. It is visible from row 1 onward this frame; row 0 shows the pre-write value.
  - Swap request while swap_pending = 1: no effect; still one swap.
  - CTRL write with bits 0 and 1 both set: back buffer cleared and swap requested; a blank frame is displayed after the boundary.
  - CTRL write on the same cycle as a boundary swap, bit0 = 1: the current swap completes and swap_pending is set again for the next boundary.
  - Row writes while swap_pending = 1: permitted; they are included in the pending frame.
- Reset mid-frame: all state returns to reset values on the next edge. Any pending swap and both buffers' contents are discarded.

Optional Feature:
- Macro: LED_ACTIVE_LOW_EN.
- Defined: led_x and led_y are driven inverted, i.e. the active-low matrix. Reset values become 8'hFF on both, and the selected row bit is 0.
- Undefined: active-high as described above. Internal state and io_rdata are unaffected in both cases.

Test Plan:
- Reset, then idle 8*SCAN_DIV cycles -> led_x = 8'h00 throughout; led_y walks 8'h01, 8'h02 ... 8'h80, each held SCAN_DIV cycles, first change SCAN_DIV cycles after reset release.
- Write back rows 0..7 = 8'hA0..8'hA7, then CTRL = 8'h01 -> STATUS reads 8'h01 until the next row-0 tick. From then on, row r shows led_x = 8'hA0+r, and STATUS reads 8'h02.
- Read BASE+3 after writing 8'h5C -> io_rdata = 8'h5C exactly one cycle after the read strobe. Read BASE+10 -> io_rdata unchanged.
- With front showing a pattern, write CTRL = 8'h03 -> after the boundary all rows show led_x = 8'h00. The old pattern is now in back: read BASE+0 returns the old row 0.
- Issue two swap requests in one frame -> exactly one buf_sel flip; frame_tog toggles once.
- Assert reset for one cycle mid-frame with swap pending -> next cycle led_x = led_y = 8'h00 and STATUS = 8'h00. With LED_ACTIVE_LOW_EN defined, led_x = led_y = 8'hFF.
